// File: rtl/le_merge_arb_pkg.sv
// rtl/le_merge_arb_pkg.sv - token types and arbiter state encoding for the Link Element merge arbiter
package le_merge_arb_pkg;

  localparam int FTK_DW = 8;

  typedef struct packed {
    logic              v;
    logic              r;
    logic [FTK_DW-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_st_t;

  // Back-prop seen by a requesting source that does not own the link
  localparam BTk_t BTK_NACK = '{n: 1'b1, t: 1'b0, v: 1'b0, c: 1'b0};

endpackage

// File: rtl/le_rr_pick2.sv
// rtl/le_rr_pick2.sv - combinational two-way round-robin pick
module le_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A single requester wins outright; a tie goes to the input not served last
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/le_merge_arb.sv
// rtl/le_merge_arb.sv - message-atomic two-input merge arbiter feeding the Link Element buffer
module le_merge_arb
  import le_merge_arb_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int WIDTH_TO  = $clog2(TIMEOUT + 1),
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  FTk_t       I_FTk0,
  output BTk_t       O_BTk0,
  input  FTk_t       I_FTk1,
  output BTk_t       O_BTk1,
  output FTk_t       O_FTk,
  input  BTk_t       I_BTk,
  output logic [1:0] O_Grant,
  output logic       O_Busy,
  output logic       O_Err
);

  localparam logic [WIDTH_TO-1:0] TO_LAST = WIDTH_TO'(TIMEOUT - 1);

  arb_st_t             state, state_nx;
  logic [WIDTH_TO-1:0] cnt, cnt_nx;
  logic                last, last_nx;
  logic                err, err_nx;
  FTk_t                r_ftk, r_ftk_nx;
  logic [1:0]          pick;
  logic [1:0]          win;
  logic                own;
  FTk_t                tok;

  le_rr_pick2 u_pick (
    .req  ({I_FTk1.v, I_FTk0.v}),
    .last (last),
    .gnt  (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      last  <= ~PRIO_INIT;
      err   <= 1'b0;
      r_ftk <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      err   <= err_nx;
      r_ftk <= r_ftk_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    err_nx   = err;
    r_ftk_nx = '0;
    win      = 2'b00;
    own      = 1'b0;
    tok      = '0;
    case (state)
      ARB_IDLE: begin
        win    = pick;
        own    = pick[1];
        tok    = pick[1] ? I_FTk1 : I_FTk0;
        cnt_nx = '0;
        if ((pick != 2'b00) && !I_BTk.n) begin
          r_ftk_nx = tok;
          if (tok.r) last_nx  = own;
          else       state_nx = own ? ARB_GNT1 : ARB_GNT0;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        own = (state == ARB_GNT1);
        win = own ? 2'b10 : 2'b01;
        tok = own ? I_FTk1 : I_FTk0;
        // Nack cycles neither accept nor count toward the idle timeout
        if (!I_BTk.n) begin
          if (tok.v) begin
            r_ftk_nx = tok;
            cnt_nx   = '0;
            if (tok.r) begin
              state_nx = ARB_IDLE;
              last_nx  = own;
            end
          end else if (cnt == TO_LAST) begin
            state_nx = ARB_IDLE;
            err_nx   = 1'b1;
            last_nx  = own;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + WIDTH_TO'(1);
          end
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    O_BTk0 = '0;
    O_BTk1 = '0;
    if (win[0])        O_BTk0 = I_BTk;
    else if (I_FTk0.v) O_BTk0 = BTK_NACK;
    if (win[1])        O_BTk1 = I_BTk;
    else if (I_FTk1.v) O_BTk1 = BTK_NACK;
  end

  assign O_FTk   = r_ftk;
  assign O_Grant = {state == ARB_GNT1, state == ARB_GNT0};
  assign O_Busy  = (state != ARB_IDLE);
  assign O_Err   = err;

endmodule
